// File: rtl/counter_reload_seq_pkg.sv
// Shared types and defaults for the counter reload sequencer.
// State encodings are fixed (IDLE=0, LOAD=1, RUN=2) so they stay stable across builds.
package counter_reload_seq_pkg;

    localparam int WIDTH_DEF = 5;
    localparam int DEPTH_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/counter_reload_seq_if.sv
// Reload-value handshake between a producer (master) and the sequencer (slave).
interface counter_reload_seq_if #(
    parameter int WIDTH = counter_reload_seq_pkg::WIDTH_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/counter_reload_seq_reload_fifo.sv
// Synchronous show-ahead FIFO holding queued reload values (DEPTH x WIDTH, DEPTH a power of 2).
module reload_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/counter_reload_seq.sv
// Reload sequencer for a loadable up-counter: queues reload values and swaps them in at terminal count.
// Build option COUNTER_RELOAD_AUTO_EN: with an empty queue, repeat the last period instead of freezing.
//
//   state | meaning
//   IDLE  | counter frozen (load=1), waiting for a queued value
//   LOAD  | counter samples load/data at the end of this cycle
//   RUN   | counter free-running, watching for TC_VALUE-1
module counter_reload_seq
    import counter_reload_seq_pkg::*;
#(
    parameter int               WIDTH    = WIDTH_DEF,
    parameter int               DEPTH    = DEPTH_DEF,
    parameter logic [WIDTH-1:0] TC_VALUE = {WIDTH{1'b1}}
) (
    input  logic                 clk,
    input  logic                 rst,
    counter_reload_seq_if.slave  in_if,
    input  logic [WIDTH-1:0]     cnt,
    output logic                 load,
    output logic [WIDTH-1:0]     data,
    output logic                 busy,
    output logic                 tc_pulse
);
    localparam logic [WIDTH-1:0] PRE_TC = TC_VALUE - {{(WIDTH-1){1'b0}}, 1'b1};

    seq_state_e       state_q, state_d;
    logic             load_q, load_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             tc_q, tc_d;
    logic             freeze_q, freeze_d;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_head;
    logic             pre_tc_hit;

    reload_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_if.in_valid && in_if.in_ready),
        .pop   (fifo_pop),
        .wdata (in_if.in_data),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign in_if.in_ready = !fifo_full;
    assign pre_tc_hit     = !load_q && (cnt == PRE_TC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            load_q   <= 1'b1;
            data_q   <= '0;
            tc_q     <= 1'b0;
            freeze_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            load_q   <= load_d;
            data_q   <= data_d;
            tc_q     <= tc_d;
            freeze_q <= freeze_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load_d   = load_q;
        data_d   = data_q;
        tc_d     = 1'b0;
        freeze_d = freeze_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                load_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    data_d   = fifo_head;
                    freeze_d = 1'b0;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // A freeze load parks the counter at TC_VALUE, so load stays high.
                if (freeze_q) begin
                    state_d = ST_IDLE;
                end else begin
                    load_d  = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (pre_tc_hit) begin
                    tc_d    = 1'b1;
                    load_d  = 1'b1;
                    state_d = ST_LOAD;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        data_d   = fifo_head;
                        freeze_d = 1'b0;
                    end else begin
`ifdef COUNTER_RELOAD_AUTO_EN
                        data_d   = data_q;
                        freeze_d = 1'b0;
`else
                        data_d   = TC_VALUE;
                        freeze_d = 1'b1;
`endif
                    end
                end
            end
            default: begin
                load_d  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign load     = load_q;
    assign data     = data_q;
    assign tc_pulse = tc_q;
    assign busy     = (state_q != ST_IDLE);

endmodule
